// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker
//
// UART receive framing engine. Detects a start bit on the synchronised RX
// line, samples every bit at its middle using an oversampling tick, checks
// the stop bit(s) and, optionally, a parity bit. It then reports an accepted
// frame, a framing error or a parity error. After a framing error the line is
// held in a recovery state until it has been high for one full bit time.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data bits; PARITY_ODD selects odd/even
//   undefined : no parity bit, parity_err is tied low, PARITY_ODD is ignored
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9), LSB first
//   STOP_BITS   stop bits checked (1 or 2)
//   OVERSAMPLE  sample_tick pulses per bit time (even, >= 4)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   sample_tick  one-clk pulse at OVERSAMPLE x baud; the FSM advances only on it
//   serial_in    pre-synchronised RX line, idle high
//   rx_data      data of the last accepted frame
//   rx_valid     one-clk pulse, frame accepted
//   stop_valid   one-clk pulse, coincident with rx_valid
//   fram_err     one-clk pulse, a stop bit was sampled low
//   parity_err   one-clk pulse, parity mismatch on an accepted frame
//   pullup_en    high from a framing error until the line has recovered
//   busy         high whenever the FSM is not idle

module uart_rx_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 stop_valid,
    output logic                 fram_err,
    output logic                 parity_err,
    output logic                 pullup_en,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int RW = $clog2(OVERSAMPLE + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [RW-1:0] REC_LAST  = RW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
`endif

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [RW-1:0]        rec_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    // A full-bit sample instant inside DATA/PARITY/STOP. The tick counter
    // restarts at mid-start, so wrapping it lands every sample mid-bit.
    logic full_tick;
    assign full_tick = (tick_cnt == FULL_LAST);

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            rec_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            stop_valid <= 1'b0;
            fram_err   <= 1'b0;
            pullup_en  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one clk regardless of the tick rate.
            rx_valid   <= 1'b0;
            stop_valid <= 1'b0;
            fram_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (serial_in) begin
                                // Line went back high before mid-start: a glitch.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (full_tick) begin
                            tick_cnt  <= '0;
                            shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (full_tick) begin
                            tick_cnt   <= '0;
                            // XOR of data and parity bit is 1 for a mismatch
                            // with even parity and 0 with odd parity.
                            parity_bad <= (^shift_reg) ^ serial_in ^ (PARITY_ODD != 0);
                            state      <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif

                    STOP: begin
                        if (full_tick) begin
                            tick_cnt <= '0;
                            if (!serial_in) begin
                                // Remaining stop bits are not sampled.
                                fram_err  <= 1'b1;
                                pullup_en <= 1'b1;
                                rec_cnt   <= '0;
                                bit_cnt   <= '0;
                                state     <= RECOVER;
                            end else if (bit_cnt == STOP_LAST) begin
                                // Returning to IDLE at mid-stop lets a
                                // back-to-back start edge be caught in time.
                                rx_data    <= shift_reg;
                                rx_valid   <= 1'b1;
                                stop_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err <= parity_bad;
`endif
                                bit_cnt    <= '0;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    RECOVER: begin
                        // The count leaves the state on reaching OVERSAMPLE,
                        // so it never needs to go past that value.
                        if (!serial_in) begin
                            rec_cnt <= '0;
                        end else if (rec_cnt == REC_LAST) begin
                            rec_cnt   <= '0;
                            pullup_en <= 1'b0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            rec_cnt <= rec_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb_uart_rx_frame_checker
//
// Directed bench for uart_rx_frame_checker. dut1 is the default 8-bit,
// one-stop-bit, 16x receiver driven from a table of frames; dut2 is a 5-bit,
// two-stop-bit, 8x receiver used for the second-stop-bit corner case.
// Ticks are issued one clk apart with an idle clk between them so that the
// hold behaviour with sample_tick low is exercised throughout.

module tb_uart_rx_frame_checker;

    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int OS2 = 8;
    localparam int DB2 = 5;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int N1      = 1 + DB + PB + 1;
    localparam int N2      = 1 + DB2 + PB + 2;
    localparam int ACCEPT1 = OS / 2 + (DB + PB + 1) * OS;
    localparam int ACCEPT2 = OS2 / 2 + (DB2 + PB + 2) * OS2;

    logic           clk;
    logic           rst;
    logic           sample_tick;
    logic           ser1;
    logic           ser2;
    logic [DB-1:0]  rx_data1;
    logic           rx_valid1, stop_valid1, fram_err1, parity_err1, pullup_en1, busy1;
    logic [DB2-1:0] rx_data2;
    logic           rx_valid2, stop_valid2, fram_err2, parity_err2, pullup_en2, busy2;

    uart_rx_frame_checker #(
        .DATA_BITS(DB), .STOP_BITS(1), .OVERSAMPLE(OS), .PARITY_ODD(0)
    ) dut1 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .serial_in(ser1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .stop_valid(stop_valid1),
        .fram_err(fram_err1), .parity_err(parity_err1),
        .pullup_en(pullup_en1), .busy(busy1)
    );

    uart_rx_frame_checker #(
        .DATA_BITS(DB2), .STOP_BITS(2), .OVERSAMPLE(OS2), .PARITY_ODD(0)
    ) dut2 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .serial_in(ser2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .stop_valid(stop_valid2),
        .fram_err(fram_err2), .parity_err(parity_err2),
        .pullup_en(pullup_en2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    int total = 0;
    int bad   = 0;
    int v1, s1, f1, p1, v2, s2, f2, p2;
    int stuck = 0;
    int cur_k = -1;
    int valid_k1, valid_k2;

    // One comparison: counts it and reports a miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearCounts();
        v1 = 0; s1 = 0; f1 = 0; p1 = 0;
        v2 = 0; s2 = 0; f2 = 0; p2 = 0;
        valid_k1 = -1; valid_k2 = -1;
    endtask

    // One tick with the given line levels, then one clk without a tick.
    // Pulses are tallied after the tick edge; any pulse still high after the
    // non-tick clk is a pulse longer than one clk.
    task automatic tickOnce(input logic l1, input logic l2);
        ser1 = l1;
        ser2 = l2;
        sample_tick = 1'b1;
        @(negedge clk);
        if (rx_valid1)   begin v1++; valid_k1 = cur_k; end
        if (stop_valid1) s1++;
        if (fram_err1)   f1++;
        if (parity_err1) p1++;
        if (rx_valid2)   begin v2++; valid_k2 = cur_k; end
        if (stop_valid2) s2++;
        if (fram_err2)   f2++;
        if (parity_err2) p2++;
        sample_tick = 1'b0;
        @(negedge clk);
        if (rx_valid1 | stop_valid1 | fram_err1 | parity_err1 |
            rx_valid2 | stop_valid2 | fram_err2 | parity_err2)
            stuck++;
    endtask

    // Frame bit vector for dut1: bit 0 is the start bit.
    function automatic logic [15:0] mk1(input logic [7:0] d, input logic p, input logic stop);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        b[8:1] = d;
`ifdef UART_RX_PARITY_EN
        b[9] = p;
        b[10] = stop;
`else
        b[9] = stop;
        if (p) b[15] = 1'b1;
`endif
        return b;
    endfunction

    function automatic logic [15:0] mk2(input logic [4:0] d, input logic st1, input logic st2);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        b[5:1] = d;
`ifdef UART_RX_PARITY_EN
        b[6] = ^d;
        b[7] = st1;
        b[8] = st2;
`else
        b[6] = st1;
        b[7] = st2;
`endif
        return b;
    endfunction

    task automatic sendBits1(input logic [15:0] b, input int n);
        for (int k = 0; k < n * OS; k++) begin
            cur_k = k;
            tickOnce(b[k / OS], 1'b1);
        end
        cur_k = -1;
    endtask

    task automatic sendBits2(input logic [15:0] b, input int n);
        for (int k = 0; k < n * OS2; k++) begin
            cur_k = k;
            tickOnce(1'b1, b[k / OS2]);
        end
        cur_k = -1;
    endtask

    // One table entry on dut1: optional idle gap, the frame, and for a bad
    // stop bit 20 low bit times followed by the recovery window.
    task automatic applyStimulus(input vec_t v);
        repeat (v.idle) tickOnce(1'b1, 1'b1);
        clearCounts();
        sendBits1(mk1(v.data, ^v.data, v.stop), N1);
        if (!v.stop) begin
            checkOutput("busy in recover", 32'(busy1), 32'd1);
            repeat (20 * OS) tickOnce(1'b0, 1'b1);
            repeat (OS - 1) tickOnce(1'b1, 1'b1);
            checkOutput("pullup held", 32'(pullup_en1), 32'd1);
            tickOnce(1'b1, 1'b1);
            checkOutput("pullup released", 32'(pullup_en1), 32'd0);
        end
        checkOutput("rx_valid count", v1, 32'(v.exp_valid));
        checkOutput("stop_valid count", s1, 32'(v.exp_valid));
        checkOutput("fram_err count", f1, 32'(v.exp_ferr));
        checkOutput("parity_err count", p1, 32'd0);
        checkOutput("rx_data", 32'(rx_data1), 32'(v.exp_rx));
        checkOutput("busy after frame", 32'(busy1), 32'd0);
        if (v.exp_valid)
            checkOutput("accept tick", valid_k1, ACCEPT1);
    endtask

    initial begin
        vec_t rv;
        // data, stop bit, idle ticks before, expect valid, expect ferr, expected rx_data
        vecs[0] = '{8'hA5, 1'b1, 3, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 3, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{8'h55, 1'b1, 3, 1'b1, 1'b0, 8'h55};
        vecs[3] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 2, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'h81, 1'b0, 1, 1'b0, 1'b1, 8'hFF};
        vecs[6] = '{8'h01, 1'b1, 4, 1'b1, 1'b0, 8'h01};

        rst = 1'b1;
        sample_tick = 1'b0;
        ser1 = 1'b1;
        ser2 = 1'b1;
        clearCounts();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(busy1), 32'd0);
        checkOutput("reset rx_data", 32'(rx_data1), 32'd0);
        checkOutput("reset pullup", 32'(pullup_en1), 32'd0);
        checkOutput("reset pulses", 32'({rx_valid1, stop_valid1, fram_err1, parity_err1}), 32'd0);

        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i]);

        // Start-bit glitch: 4 low ticks then high, rejected at mid-start.
        repeat (3) tickOnce(1'b1, 1'b1);
        clearCounts();
        tickOnce(1'b0, 1'b1);
        checkOutput("glitch busy rise", 32'(busy1), 32'd1);
        repeat (3) tickOnce(1'b0, 1'b1);
        repeat (4) tickOnce(1'b1, 1'b1);
        checkOutput("glitch busy before mid", 32'(busy1), 32'd1);
        tickOnce(1'b1, 1'b1);
        checkOutput("glitch busy after mid", 32'(busy1), 32'd0);
        checkOutput("glitch pulses", v1 + s1 + f1 + p1, 32'd0);

        // Reset in the middle of the data bits of 0x81.
        clearCounts();
        for (int k = 0; k < 50; k++) begin
            tickOnce(mk1(8'h81, 1'b0, 1'b1)[k / OS], 1'b1);
        end
        checkOutput("busy mid data", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid reset busy", 32'(busy1), 32'd0);
        checkOutput("mid reset pulses", 32'({rx_valid1, stop_valid1, fram_err1, parity_err1}), 32'd0);
        checkOutput("mid reset pullup", 32'(pullup_en1), 32'd0);
        checkOutput("mid reset rx_data", 32'(rx_data1), 32'd0);
        repeat (20) tickOnce(1'b1, 1'b1);
        checkOutput("abandoned frame pulses", v1 + s1 + f1 + p1, 32'd0);
        rv = '{8'hFF, 1'b1, 0, 1'b1, 1'b0, 8'hFF};
        applyStimulus(rv);

`ifdef UART_RX_PARITY_EN
        // Even parity over 0x07 is 1: bit 0 mismatches, bit 1 matches.
        repeat (2) tickOnce(1'b1, 1'b1);
        clearCounts();
        sendBits1(mk1(8'h07, 1'b0, 1'b1), N1);
        checkOutput("parity bad valid", v1, 32'd1);
        checkOutput("parity bad err", p1, 32'd1);
        clearCounts();
        sendBits1(mk1(8'h07, 1'b1, 1'b1), N1);
        checkOutput("parity good valid", v1, 32'd1);
        checkOutput("parity good err", p1, 32'd0);
        checkOutput("parity rx_data", 32'(rx_data1), 32'h07);
`endif

        // dut2: good frame with two stop bits.
        repeat (2) tickOnce(1'b1, 1'b1);
        clearCounts();
        sendBits2(mk2(5'h13, 1'b1, 1'b1), N2);
        checkOutput("2stop valid", v2, 32'd1);
        checkOutput("2stop stop_valid", s2, 32'd1);
        checkOutput("2stop ferr", f2, 32'd0);
        checkOutput("2stop rx_data", 32'(rx_data2), 32'h13);
        checkOutput("2stop accept tick", valid_k2, ACCEPT2);
        checkOutput("2stop busy", 32'(busy2), 32'd0);

        // dut2: first stop bit high, second low.
        clearCounts();
        sendBits2(mk2(5'h0A, 1'b1, 1'b0), N2);
        checkOutput("2nd stop low ferr", f2, 32'd1);
        checkOutput("2nd stop low valid", v2, 32'd0);
        checkOutput("2nd stop low busy", 32'(busy2), 32'd1);
        checkOutput("2nd stop low pullup", 32'(pullup_en2), 32'd1);
        checkOutput("2nd stop low rx_data", 32'(rx_data2), 32'h13);
        repeat (OS2 - 1) tickOnce(1'b1, 1'b1);
        checkOutput("dut2 pullup held", 32'(pullup_en2), 32'd1);
        tickOnce(1'b1, 1'b1);
        checkOutput("dut2 pullup released", 32'(pullup_en2), 32'd0);
        checkOutput("dut2 busy released", 32'(busy2), 32'd0);

        checkOutput("dut1 untouched by dut2 frames", v1 + f1, 32'd0);
        checkOutput("pulse width", stuck, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_checker.md
# uart_rx_frame_checker

Parametrised UART receive framing engine. It detects the start bit, samples data, optional parity and stop bits at mid-bit using an oversampling tick, and reports a valid frame, a framing error or a parity error. It sits between the serial input synchroniser and the receive FIFO/register interface of the UART peripheral. It generalises single-cycle stop-bit checking into a full frame state machine with configurable width, stop bits, oversampling and line-break recovery.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9, LSB first
- STOP_BITS, 1, stop bits checked, 1 or 2
- OVERSAMPLE, 16, sample_tick pulses per bit time, even, >= 4
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sample_tick  input  1  one-clk pulse at OVERSAMPLE × baud; state advances only on ticks
- serial_in  input  1  pre-synchronised RX line, idle high
- rx_data  output  DATA_BITS  last good frame's data; holds until the next good frame
- rx_valid  output  1  one-clk pulse, frame accepted (stop bits good)
- stop_valid  output  1  one-clk pulse, coincident with rx_valid
- fram_err  output  1  one-clk pulse, a stop bit was sampled low
- parity_err  output  1  one-clk pulse, parity mismatch on an accepted frame
- pullup_en  output  1  high from a framing error until line recovery completes
- busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP, RECOVER. Transitions are evaluated only on clk edges where sample_tick = 1. With sample_tick = 0, all state, counters and outputs except the pulses hold.
- IDLE: serial_in = 0 on a tick → START. This tick is T0 and the tick counter is cleared.
- START: on tick T0+OVERSAMPLE/2 (mid-start), sample serial_in.
  - 1 → IDLE (glitch). No flags.
  - 0 → DATA. Tick counter cleared.
- DATA: sample every OVERSAMPLE ticks. Shift right into the shift register, so the first bit received ends up in rx_data[0]. After DATA_BITS samples → PARITY if enabled, else STOP.
- PARITY: one sample p. Mismatch condition:
  - even: XOR(data) ^ p = 1
  - odd: XOR(data) ^ p = 0
- STOP: one sample per stop bit.
  - Any 0 sample → framing failure at once; remaining stop bits are not sampled. fram_err pulses. rx_data, rx_valid and parity_err do not change. pullup_en ← 1. → RECOVER.
  - Last stop sample is 1 → rx_data ← shift register. rx_valid and stop_valid pulse, and parity_err pulses if there was a mismatch. → IDLE at mid-stop, so back-to-back frames resynchronise.
- RECOVER: count consecutive ticks with serial_in = 1. Any 0 clears the count. When the count reaches OVERSAMPLE: pullup_en ← 0, → IDLE.
- Counters:
  - tick counter: $clog2(OVERSAMPLE) bits, wraps at OVERSAMPLE-1
  - bit counter: $clog2(DATA_BITS+1) bits
  - recovery counter: $clog2(OVERSAMPLE+1) bits, saturating
- Reset values: state IDLE; rx_data 0; all pulses 0; pullup_en 0; busy 0; all counters 0. A reset mid-frame abandons the frame and emits no pulse.

## Timing
- All outputs are registered. Pulses are high for exactly one clk, in the cycle after the deciding tick edge.
- Sample instants, with P = 1 if parity is enabled, else 0:
  - start bit: T0+OVERSAMPLE/2
  - data bit i: T0+OVERSAMPLE/2+(i+1)·OVERSAMPLE
  - parity bit: T0+OVERSAMPLE/2+(DATA_BITS+1)·OVERSAMPLE
  - stop bit k: T0+OVERSAMPLE/2+(DATA_BITS+P+1+k)·OVERSAMPLE
- Example: 8N1 with OVERSAMPLE=16 accepts at T0+152 ticks.
- busy rises on the tick edge that detects the start bit. It falls on the edge that enters IDLE.
- A new start edge is recognised on the first tick after returning to IDLE.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state and parity checker are present. PARITY_ODD selects the polarity.
- UART_RX_PARITY_EN undefined: no PARITY state; STOP follows DATA directly. parity_err is tied 0 and PARITY_ODD is ignored.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 → rx_data=0xA5; rx_valid and stop_valid pulse 1 clk at T0+152 ticks; fram_err=0, busy=0 after.
- Send 0x3C with stop bit low, line low for 20 bit times, then high → fram_err pulse, rx_valid=0, rx_data keeps its old value. pullup_en stays high until 16 consecutive high ticks, then falls. A following 0x55 is received correctly.
- serial_in low for 4 ticks, then high → START returns to IDLE at mid-start; no pulses; busy low again.
- Macro on, even parity, 0x07 with parity bit 0 → rx_valid=1 and parity_err=1. Same data with parity bit 1 → parity_err=0.
- Assert rst mid-DATA of 0x81 → next clk: busy=0, all pulses 0, pullup_en=0. A following 0xFF is received.
- STOP_BITS=2, first stop bit 1, second stop bit 0 → fram_err pulse, no rx_valid, RECOVER entered.
